// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router: packet field positions, port directions
// and the XY routing helpers used by every input stage.
package noc_pkg;

    localparam int WIDTH_packet = 57;

    localparam int SRC_HI  = 56;
    localparam int SRC_LO  = 53;
    localparam int DSTX_HI = 52;
    localparam int DSTX_LO = 51;
    localparam int DSTY_HI = 50;
    localparam int DSTY_LO = 49;

    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_E = 3'd1,
        DIR_S = 3'd2,
        DIR_W = 3'd3,
        DIR_L = 3'd4
    } dir_e;

    // Dimension-ordered routing: resolve X completely before touching Y.
    function automatic dir_e xy_route(input logic [1:0] dstx, input logic [1:0] dsty,
                                      input logic [1:0] myx, input logic [1:0] myy);
        dir_e dir;
        if (dstx > myx) begin
            dir = DIR_E;
        end else if (dstx < myx) begin
            dir = DIR_W;
        end else if (dsty > myy) begin
            dir = DIR_N;
        end else if (dsty < myy) begin
            dir = DIR_S;
        end else begin
            dir = DIR_L;
        end
        return dir;
    endfunction

    // Each stage only feeds the four other ports, so its own port is squeezed out
    // of the index space. The result is meaningless when dir equals port_id.
    function automatic logic [1:0] dir_to_idx(input dir_e dir, input logic [2:0] port_id);
        logic [2:0] d;
        logic [2:0] dm1;
        d   = 3'(dir);
        dm1 = d - 3'd1;
        return (d < port_id) ? d[1:0] : dm1[1:0];
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Small first-word-fall-through FIFO; the head entry is readable combinationally
// so the route decision can be made in the same cycle the packet lands.
module noc_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 57,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer MSB tells a wrapped (full) FIFO apart from an empty one.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/noc_input_ctrl.sv
// Router input stage: buffers packets from one port, XY-routes the head packet to
// one of four output controllers and discards packets that would turn back.
module noc_input_ctrl
    import noc_pkg::*;
#(
    parameter int WIDTH_packet = noc_pkg::WIDTH_packet,
    parameter int DEPTH        = 4,
    parameter int MY_X         = 0,
    parameter int MY_Y         = 0,
    parameter int PORT_ID      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH_packet-1:0] in_data,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic [WIDTH_packet-1:0] out_data,
    output logic [7:0]              drop_cnt
);

    localparam logic [1:0] MY_X_L    = 2'(MY_X);
    localparam logic [1:0] MY_Y_L    = 2'(MY_Y);
    localparam logic [2:0] PORT_ID_L = 3'(PORT_ID);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [WIDTH_packet-1:0] head;
    dir_e                    head_dir;
    logic [1:0]              head_idx;
    logic [1:0]              head_state;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign out_data  = head;
    assign drop_cnt  = drop_cnt_q;

    noc_fifo #(
        .WIDTH (WIDTH_packet),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // The head state is decoded from the registered FIFO head, so a new head is
    // presented (or dropped) in the very cycle it becomes visible.
    always_comb begin
        head_dir   = xy_route(head[DSTX_HI:DSTX_LO], head[DSTY_HI:DSTY_LO], MY_X_L, MY_Y_L);
        head_idx   = dir_to_idx(head_dir, PORT_ID_L);
        head_state = ST_EMPTY;
        if (!fifo_empty) begin
            head_state = (3'(head_dir) == PORT_ID_L) ? ST_DROP : ST_SEND;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_out_valid
        assign out_valid[gi] = (head_state == ST_SEND) && (head_idx == 2'(gi));
    end

    always_comb begin
        fifo_pop   = 1'b0;
        drop_cnt_d = drop_cnt_q;
        case (head_state)
            ST_SEND: fifo_pop = out_ready[head_idx];
            ST_DROP: begin
                fifo_pop = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_noc_input_ctrl.sv
// Directed and random checks of two input stages (local port and east port of
// router (1,1)) against a queue-based model of the routing/drop rules.
module tb_noc_input_ctrl;

    localparam int P0 = 4;
    localparam int P1 = 1;

    logic        clk;
    logic        rst_n;
    logic        iv0, iv1;
    logic        ir0, ir1;
    logic [56:0] id0, id1;
    logic [3:0]  ov0, ov1;
    logic [3:0]  or0, or1;
    logic [56:0] od0, od1;
    logic [7:0]  dc0, dc1;

    int          errors = 0;
    int          checks = 0;
    logic [56:0] q0[$];
    logic [56:0] q1[$];
    int          md0, md1;
    logic        acc0, acc1;
    logic [56:0] saved;

    noc_input_ctrl #(.WIDTH_packet(57), .DEPTH(4), .MY_X(1), .MY_Y(1), .PORT_ID(P0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .drop_cnt(dc0)
    );

    noc_input_ctrl #(.WIDTH_packet(57), .DEPTH(4), .MY_X(1), .MY_Y(1), .PORT_ID(P1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .drop_cnt(dc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Router at (1,1): E/W if X differs, else N/S if Y differs, else local.
    function automatic int route_dir(input logic [56:0] p);
        int dx, dy;
        dx = int'(p[52:51]);
        dy = int'(p[50:49]);
        if (dx > 1) return 1;
        if (dx < 1) return 3;
        if (dy > 1) return 0;
        if (dy < 1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_ov(input int port, input logic [56:0] p);
        int d, idx;
        d = route_dir(p);
        if (d == port) return 4'b0000;
        idx = (d < port) ? d : d - 1;
        return 4'(1 << idx);
    endfunction

    function automatic logic [56:0] rpkt();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[56:0];
    endfunction

    function automatic logic [56:0] mk(input logic [1:0] dx, input logic [1:0] dy);
        logic [56:0] p;
        p = rpkt();
        p[52:51] = dx;
        p[50:49] = dy;
        return p;
    endfunction

    // Check both stages against the model, then advance one clock and update it.
    task automatic cycle();
        logic [3:0]  e0, e1;
        logic        push0, push1, pop0, pop1, drop0, drop1;
        logic [56:0] tmp;
        #1;
        e0 = (q0.size() == 0) ? 4'b0 : exp_ov(P0, q0[0]);
        e1 = (q1.size() == 0) ? 4'b0 : exp_ov(P1, q1[0]);
        chk("in_ready0", 64'(ir0), 64'(q0.size() < 4));
        chk("out_valid0", 64'(ov0), 64'(e0));
        if (q0.size() != 0) chk("out_data0", 64'(od0), 64'(q0[0]));
        chk("drop_cnt0", 64'(dc0), 64'(md0));
        chk("in_ready1", 64'(ir1), 64'(q1.size() < 4));
        chk("out_valid1", 64'(ov1), 64'(e1));
        if (q1.size() != 0) chk("out_data1", 64'(od1), 64'(q1[0]));
        chk("drop_cnt1", 64'(dc1), 64'(md1));
        push0 = iv0 && (q0.size() < 4);
        push1 = iv1 && (q1.size() < 4);
        drop0 = (q0.size() != 0) && (e0 == 4'b0);
        drop1 = (q1.size() != 0) && (e1 == 4'b0);
        pop0  = drop0 || ((e0 & or0) != 4'b0);
        pop1  = drop1 || ((e1 & or1) != 4'b0);
        @(posedge clk);
        #1;
        if (pop0) tmp = q0.pop_front();
        if (pop1) tmp = q1.pop_front();
        if (push0) q0.push_back(id0);
        if (push1) q1.push_back(id1);
        if (drop0 && md0 < 255) md0++;
        if (drop1 && md1 < 255) md1++;
        acc0 = push0;
        acc1 = push1;
    endtask

    task automatic do_reset();
        iv0 = 1'b0;
        iv1 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        md0 = 0;
        md1 = 0;
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    logic [1:0] map_dst [4][2];
    logic [3:0] map_exp [4];

    initial begin
        rst_n = 1'b1;
        iv0 = 1'b0; iv1 = 1'b0;
        id0 = '0;   id1 = '0;
        or0 = '0;   or1 = '0;
        md0 = 0;    md1 = 0;
        acc0 = 1'b0; acc1 = 1'b0;
        map_dst[0] = '{2'd1, 2'd2}; map_exp[0] = 4'b0001;
        map_dst[1] = '{2'd1, 2'd0}; map_exp[1] = 4'b0010;
        map_dst[2] = '{2'd0, 2'd1}; map_exp[2] = 4'b0100;
        map_dst[3] = '{2'd1, 2'd1}; map_exp[3] = 4'b1000;
        #2;
        do_reset();

        // Reset state
        #1;
        chk("rst_out_valid", 64'(ov0), 64'(4'b0));
        chk("rst_in_ready", 64'(ir0), 64'(1'b1));
        chk("rst_drop_cnt", 64'(dc0), 64'(8'd0));

        // Single packet to the east
        iv0 = 1'b1; id0 = mk(2'd2, 2'd1); or0 = 4'b0000;
        cycle();
        chk("single_valid", 64'(ov0), 64'(4'b0010));
        chk("single_data", 64'(od0), 64'(id0));
        iv0 = 1'b0; or0 = 4'b0010;
        cycle();
        chk("single_popped", 64'(ov0), 64'(4'b0000));

        // Backpressure: five packets westbound, nothing accepted
        or0 = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            iv0 = 1'b1; id0 = mk(2'd0, 2'd1);
            cycle();
        end
        chk("full_in_ready", 64'(ir0), 64'(1'b0));
        saved = od0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_data_stable", 64'(od0), 64'(saved));
        end
        iv0 = 1'b0; or0 = 4'b1111;
        for (int i = 0; i < 6; i++) cycle();
        chk("drained_in_ready", 64'(ir0), 64'(1'b1));

        // Single self-addressed drop
        iv0 = 1'b1; id0 = mk(2'd1, 2'd1);
        cycle();
        iv0 = 1'b0;
        chk("drop_no_valid", 64'(ov0), 64'(4'b0000));
        cycle();
        chk("drop_cnt_one", 64'(dc0), 64'(8'd1));

        // Saturation after 300 more drops
        for (int i = 0; i < 300; i++) begin
            iv0 = 1'b1; id0 = mk(2'd1, 2'd1);
            cycle();
        end
        iv0 = 1'b0;
        cycle();
        cycle();
        chk("drop_cnt_sat", 64'(dc0), 64'(8'd255));

        // Output index mapping on the east port
        for (int i = 0; i < 4; i++) begin
            iv1 = 1'b1; id1 = mk(map_dst[i][0], map_dst[i][1]); or1 = 4'b0000;
            cycle();
            iv1 = 1'b0;
            chk("map_valid", 64'(ov1), 64'(map_exp[i]));
            or1 = map_exp[i];
            cycle();
        end

        // Streaming with simultaneous push and pop across pointer wrap
        or0 = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            iv0 = 1'b1; id0 = mk(2'd2, 2'($urandom_range(0, 3)));
            cycle();
            chk("stream_in_ready", 64'(ir0), 64'(1'b1));
        end
        iv0 = 1'b0;
        cycle();

        // Random traffic on both stages
        for (int i = 0; i < 400; i++) begin
            if (!iv0 || acc0) begin iv0 = 1'($urandom_range(0, 1)); id0 = rpkt(); end
            if (!iv1 || acc1) begin iv1 = 1'($urandom_range(0, 1)); id1 = rpkt(); end
            or0 = 4'($urandom());
            or1 = 4'($urandom());
            cycle();
        end
        iv0 = 1'b0; iv1 = 1'b0;
        or0 = 4'b0000;

        // Reset with packets in flight
        for (int i = 0; i < 3; i++) begin
            iv0 = 1'b1; id0 = mk(2'd2, 2'd1);
            cycle();
        end
        do_reset();
        #1;
        chk("midrst_out_valid", 64'(ov0), 64'(4'b0));
        chk("midrst_in_ready", 64'(ir0), 64'(1'b1));
        chk("midrst_drop_cnt", 64'(dc0), 64'(8'd0));
        or0 = 4'b1111; or1 = 4'b1111;
        for (int i = 0; i < 5; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
